rr_trace_pkt_packer: RTL

Record-side trace encoder. It takes variable-width record packets (logb header bits followed by the valid channel payloads, LSB-first, plus a width) and packs them back-to-back, with no gaps, into fixed AXI_WIDTH-bit beats for the trace writer. It is the inverse of the replay-side trace parser, which unpacks the same bitstream. On finish it zero-pads the final partial beat, flushes it, and reports the total number of bits packed.

---
 rtl/rr_trace_pkt_packer.sv | 95 +++++++++
 1 files changed

// File: rtl/rr_trace_pkt_packer.sv
// Record-side trace encoder: packs variable-width packets back-to-back into
// fixed AXI_WIDTH-bit beats, zero-padding and flagging the final beat on finish.
module rr_trace_pkt_packer #(
  parameter int unsigned WIDTH        = 1024,
  parameter int unsigned AXI_WIDTH    = 512,
  parameter int unsigned OFFSET_WIDTH = $clog2(WIDTH + 1),
  parameter int unsigned FILL_WIDTH   = $clog2(WIDTH + AXI_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [OFFSET_WIDTH-1:0] in_width,
  input  logic                    finish,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AXI_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic                    done,
  output logic [63:0]             total_bits
);

  localparam int unsigned BufW = WIDTH + AXI_WIDTH;
  localparam logic [FILL_WIDTH-1:0]   AxiFill  = FILL_WIDTH'(AXI_WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] WidthOff = OFFSET_WIDTH'(WIDTH);

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e                state_q, state_d;
  logic [BufW-1:0]       buf_q, buf_d;
  logic [FILL_WIDTH-1:0] fill_q, fill_d;
  logic [63:0]           total_q, total_d;

  logic                    accept, fire;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic [WIDTH-1:0]        mask;
  logic [BufW-1:0]         ins;

  // Gated by rst_n so in_ready reads 0 while reset is held.
  assign in_ready   = rst_n && (state_q == StRun) && (fill_q < AxiFill);
  assign out_valid  = (fill_q >= AxiFill) || ((state_q == StFlush) && (fill_q != '0));
  assign out_data   = buf_q[AXI_WIDTH-1:0];
  assign out_last   = (state_q == StFlush) && out_valid && (fill_q <= AxiFill);
  assign done       = (state_q == StDone);
  assign total_bits = total_q;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  always_comb begin
    w_off = (in_width > WidthOff) ? WidthOff : in_width;
    // Keeps buffer bits above fill at zero, which gives free flush padding.
    mask  = {WIDTH{1'b1}} >> (WidthOff - w_off);
    ins   = BufW'(in_data & mask) << fill_q;
  end

  always_comb begin
    buf_d   = buf_q;
    fill_d  = fill_q;
    total_d = total_q;
    state_d = state_q;

    if (accept) begin
      buf_d   = buf_q | ins;
      fill_d  = fill_q + FILL_WIDTH'(w_off);
      total_d = total_q + 64'(w_off);
    end else if (fire) begin
      buf_d  = buf_q >> AXI_WIDTH;
      fill_d = (fill_q >= AxiFill) ? (fill_q - AxiFill) : '0;
    end

    unique case (state_q)
      StRun:   if (finish) state_d = StFlush;
      StFlush: if (fill_d == '0) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      buf_q   <= '0;
      fill_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      total_q <= total_d;
    end
  end

endmodule
